bridge_router_pipe: RTL
=======================

Name: bridge_router_pipe

Overview:
- Parametrised successor to the bridge address fan-out: routes one APF bridge master port to NUM_LEAVES leaf ports by address range.
- Adds a registered decode stage, a pipelined fixed-latency read return path and a per-leaf byte-swap mode.
- Unmapped accesses return a default read value; an optional error log is available.
- Sits between the top-level bridge port and the core's bridge leaves (cmd, dataslot, id, rom, dip, hiscore).

Parameters:
NUM_LEAVES, 6, number of leaf ports (1..16)
ADDR_FROM, all-zero packed [NUM_LEAVES*32], inclusive range start per leaf; leaf i uses bits [i*32 +: 32]
ADDR_TO, all-zero packed [NUM_LEAVES*32], inclusive range end per leaf
SWAP_MASK, 0 [NUM_LEAVES], bit i=1: leaf i data is byte-reversed in both directions
LEAF_LATENCY, 1, cycles from leaf_rd pulse to valid leaf_rd_data (1..8)
UNMAPPED_DATA, 32'hDEAD_BEEF, read value for unmapped addresses
ENDIAN_LITTLE, 0, driven onto bridge_endian_little

Ports:
clk_74a  in  1  bridge clock
reset  in  1  asynchronous, active-high reset
bridge_addr  in  32  master address
bridge_wr  in  1  write strobe, one-cycle pulse
bridge_wr_data  in  32  write data
bridge_rd  in  1  read strobe, one-cycle pulse
bridge_rd_data  out  32  read data, held between reads
bridge_rd_valid  out  1  one-cycle pulse when bridge_rd_data is updated
bridge_endian_little  out  1  constant ENDIAN_LITTLE
leaf_addr  out  32  registered address, common to all leaves
leaf_wr_data  out  32  registered, swapped-per-leaf write data
leaf_wr  out  NUM_LEAVES  one-hot write pulse
leaf_rd  out  NUM_LEAVES  one-hot read pulse
leaf_rd_data  in  NUM_LEAVES*32  per-leaf read data

Behaviour:
- Reset values: all outputs 0 except bridge_endian_little, which is constant; read pipeline cleared.
- Decode:
  - Leaf i matches when ADDR_FROM[i] <= addr <= ADDR_TO[i], using unsigned 32-bit compares.
  - On overlapping ranges, the lowest matching index wins.
  - No match means unmapped.
- Write:
  - bridge_wr at cycle T produces leaf_wr[i]=1 for exactly cycle T+1.
  - leaf_addr and leaf_wr_data are valid in T+1; leaf_wr_data is byte-reversed if SWAP_MASK[i].
  - Unmapped writes are dropped: no leaf pulse.
- Read:
  - bridge_rd at cycle T produces leaf_rd[i]=1 at T+1.
  - The router samples leaf_rd_data[i] at T+1+LEAF_LATENCY, applying the swap if SWAP_MASK[i].
  - The result is registered to bridge_rd_data with bridge_rd_valid=1 at T+2+LEAF_LATENCY.
  - Total read latency is LEAF_LATENCY+2 cycles.
- Pipelining:
  - A shift register of depth LEAF_LATENCY+1 carries {valid, mapped, leaf index} per read.
  - Back-to-back reads, one per cycle, are accepted; each returns in order at fixed latency.
- Unmapped read: no leaf_rd pulse; UNMAPPED_DATA is returned at the same fixed latency with valid=1, and is not swapped.
- Simultaneous bridge_wr and bridge_rd in one cycle: the write is performed and the read is dropped (no valid pulse); counted as an error when the log is enabled.
- leaf_addr/leaf_wr_data update only on an accepted strobe; otherwise they hold.
- Reset asserted mid-read: in-flight reads are discarded and no rd_valid is issued after reset release.

Optional Feature:
Macro: BRIDGE_ROUTER_ERR_LOG_EN
- Defined: adds outputs err_count (16 bits) and err_addr (32 bits).
  - err_count increments, saturating at 16'hFFFF, on each unmapped read, unmapped write or rd/wr collision.
  - err_addr captures the address of the most recent such event.
  - Both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Ranges {0x0000_0000-0x000F_FFFF, 0xF800_0000-0xF800_1FFF}, LEAF_LATENCY=1: write 0x1234_5678 to 0x10 -> leaf_wr=2'b01 pulse at T+1, leaf_addr=0x10, leaf_wr_data=0x1234_5678.
- Read 0xF800_0004, leaf1 returns 0xAABB_CCDD with SWAP_MASK=2'b10 -> bridge_rd_data=0xDDCC_BBAA with valid at T+3.
- Reads at T, T+1, T+2 to leaf0, leaf1, unmapped 0x3000_0000 -> three valid pulses at T+3..T+5 in order; the third returns 0xDEAD_BEEF; no leaf_rd for the third.
- Overlap: leaf0 and leaf1 both cover 0x100; write 0x100 -> only leaf_wr[0] pulses.
- rd and wr asserted together at 0x10 -> leaf_wr[0] pulse, no leaf_rd, no rd_valid; with BRIDGE_ROUTER_ERR_LOG_EN, err_count=1 and err_addr=0x10.
- Reset asserted at T+1 of a read with LEAF_LATENCY=4 -> all outputs 0 immediately; no rd_valid in the 8 cycles after release.

Source files
------------

// File: rtl/bridge_router_pipe.sv
// bridge_router_pipe
//   Routes one APF bridge master port onto NUM_LEAVES leaf ports by address
//   range. The address decode is registered, read data returns through a
//   fixed-latency pipeline, and each leaf can optionally see byte-reversed data.
//
// Optional feature (define BRIDGE_ROUTER_ERR_LOG_EN):
//   err_count  out 16  saturating count of unmapped accesses and rd/wr collisions
//   err_addr   out 32  address of the most recent such event
//
// Ports:
//   clk_74a               in   1              bridge clock
//   reset                 in   1              asynchronous active-high reset
//   bridge_addr           in   32             master address
//   bridge_wr             in   1              write strobe (one-cycle pulse)
//   bridge_wr_data        in   32             write data
//   bridge_rd             in   1              read strobe (one-cycle pulse)
//   bridge_rd_data        out  32             read data, held between reads
//   bridge_rd_valid       out  1              pulses when bridge_rd_data updates
//   bridge_endian_little  out  1              constant ENDIAN_LITTLE
//   leaf_addr             out  32             registered address, all leaves
//   leaf_wr_data          out  32             registered write data (per-leaf swap)
//   leaf_wr               out  NUM_LEAVES     one-hot write pulse
//   leaf_rd               out  NUM_LEAVES     one-hot read pulse
//   leaf_rd_data          in   NUM_LEAVES*32  per-leaf read data
module bridge_router_pipe #(
  parameter int                         NUM_LEAVES    = 6,
  parameter logic [NUM_LEAVES*32-1:0]   ADDR_FROM     = '0,
  parameter logic [NUM_LEAVES*32-1:0]   ADDR_TO       = '0,
  parameter logic [NUM_LEAVES-1:0]      SWAP_MASK     = '0,
  parameter int                         LEAF_LATENCY  = 1,
  parameter logic [31:0]                UNMAPPED_DATA = 32'hDEAD_BEEF,
  parameter logic                       ENDIAN_LITTLE = 1'b0
) (
  input  logic                       clk_74a,
  input  logic                       reset,
  input  logic [31:0]                bridge_addr,
  input  logic                       bridge_wr,
  input  logic [31:0]                bridge_wr_data,
  input  logic                       bridge_rd,
  output logic [31:0]                bridge_rd_data,
  output logic                       bridge_rd_valid,
  output logic                       bridge_endian_little,
  output logic [31:0]                leaf_addr,
  output logic [31:0]                leaf_wr_data,
  output logic [NUM_LEAVES-1:0]      leaf_wr,
  output logic [NUM_LEAVES-1:0]      leaf_rd,
  input  logic [NUM_LEAVES*32-1:0]   leaf_rd_data
`ifdef BRIDGE_ROUTER_ERR_LOG_EN
  ,
  output logic [15:0]                err_count,
  output logic [31:0]                err_addr
`endif
);

  localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int DEPTH = LEAF_LATENCY + 1;

  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Per-read tag carried down the return pipeline.
  typedef struct packed {
    logic             vld;
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [NUM_LEAVES-1:0] in_range;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;

  for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_range
    assign in_range[gi] = (bridge_addr >= ADDR_FROM[gi*32 +: 32]) &&
                          (bridge_addr <= ADDR_TO[gi*32 +: 32]);
  end

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // A write wins over a simultaneous read; the read is dropped entirely.
  logic wr_go;
  logic rd_go;
  logic strobe;
  assign wr_go  = bridge_wr;
  assign rd_go  = bridge_rd & ~bridge_wr;
  assign strobe = bridge_wr | bridge_rd;

  // ---------------------------------------------------------------------------
  // Request stage
  // ---------------------------------------------------------------------------
  logic [31:0]           leaf_addr_q,    leaf_addr_d;
  logic [31:0]           leaf_wr_data_q, leaf_wr_data_d;
  logic [NUM_LEAVES-1:0] leaf_wr_q,      leaf_wr_d;
  logic [NUM_LEAVES-1:0] leaf_rd_q,      leaf_rd_d;

  always_comb begin
    leaf_addr_d    = leaf_addr_q;
    leaf_wr_data_d = leaf_wr_data_q;
    leaf_wr_d      = '0;
    leaf_rd_d      = '0;
    if (strobe) begin
      leaf_addr_d    = bridge_addr;
      leaf_wr_data_d = (hit && SWAP_MASK[hit_idx]) ? byte_rev(bridge_wr_data)
                                                   : bridge_wr_data;
    end
    if (wr_go && hit) leaf_wr_d = NUM_LEAVES'(1) << hit_idx;
    if (rd_go && hit) leaf_rd_d = NUM_LEAVES'(1) << hit_idx;
  end

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      leaf_addr_q    <= '0;
      leaf_wr_data_q <= '0;
      leaf_wr_q      <= '0;
      leaf_rd_q      <= '0;
    end else begin
      leaf_addr_q    <= leaf_addr_d;
      leaf_wr_data_q <= leaf_wr_data_d;
      leaf_wr_q      <= leaf_wr_d;
      leaf_rd_q      <= leaf_rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline: stage k holds the tag of a read issued k+1 cycles ago,
  // so the last stage lines up with the cycle the leaf data is valid.
  // ---------------------------------------------------------------------------
  rd_tag_t pipe_q [DEPTH];
  rd_tag_t pipe_d [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_d[gi] = '{vld: rd_go, mapped: hit, idx: hit_idx};
    end else begin : g_body
      assign pipe_d[gi] = pipe_q[gi-1];
    end

    always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) pipe_q[gi] <= '0;
      else       pipe_q[gi] <= pipe_d[gi];
    end
  end

  // Leaf read words with the per-leaf swap already applied.
  logic [31:0] leaf_word_sw [NUM_LEAVES];
  for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf_word
    assign leaf_word_sw[gi] = SWAP_MASK[gi] ? byte_rev(leaf_rd_data[gi*32 +: 32])
                                            : leaf_rd_data[gi*32 +: 32];
  end

  rd_tag_t     tail;
  logic [31:0] rd_data_q,  rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  assign tail = pipe_q[DEPTH-1];

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (tail.vld) begin
      rd_valid_d = 1'b1;
      if (tail.mapped && (int'(tail.idx) < NUM_LEAVES)) rd_data_d = leaf_word_sw[tail.idx];
      else                                              rd_data_d = UNMAPPED_DATA;
    end
  end

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Error log
  // ---------------------------------------------------------------------------
`ifdef BRIDGE_ROUTER_ERR_LOG_EN
  logic        err_event;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] err_addr_q,  err_addr_d;

  // A collision at an unmapped address is still a single event.
  assign err_event = (strobe && !hit) || (bridge_rd && bridge_wr);

  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (err_event) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      err_addr_d = bridge_addr;
    end
  end

  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`endif

  assign bridge_rd_data       = rd_data_q;
  assign bridge_rd_valid      = rd_valid_q;
  assign bridge_endian_little = ENDIAN_LITTLE;
  assign leaf_addr            = leaf_addr_q;
  assign leaf_wr_data         = leaf_wr_data_q;
  assign leaf_wr              = leaf_wr_q;
  assign leaf_rd              = leaf_rd_q;

endmodule
